// File: rtl/e203_exu_longpwbck_buf.sv
// Long-pipe write-back arbiter: per-channel result FIFOs, retire the head whose itag matches the OITF head.
// Optional E203_LONGPWBCK_BYPASS_EN lets an incoming result retire in its arrival cycle when its FIFO is empty.

module e203_longpwbck_fifo #(
    parameter int DEP = 2,
    parameter int W   = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int PW = (DEP > 1) ? $clog2(DEP) : 1;
    localparam int CW = $clog2(DEP + 1);

    logic [W-1:0]  mem [DEP];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            // explicit wrap so a non power-of-2 depth works
            if (push) wptr <= (wptr == PW'(DEP - 1)) ? '0 : wptr + 1'b1;
            if (pop)  rptr <= (rptr == PW'(DEP - 1)) ? '0 : rptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    assign dout  = mem[rptr];
    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEP));
endmodule

module e203_exu_longpwbck_buf #(
    parameter int                CH_NUM       = 2,
    parameter int                XLEN         = 32,
    parameter int                ITAG_W       = 5,
    parameter int                BUF_DEP      = 2,
    parameter logic [CH_NUM-1:0] CH_EXCP_MASK = 2'b01
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CH_NUM-1:0]        ch_wbck_i_valid,
    output logic [CH_NUM-1:0]        ch_wbck_i_ready,
    input  logic [CH_NUM*XLEN-1:0]   ch_wbck_i_wdat,
    input  logic [CH_NUM*ITAG_W-1:0] ch_wbck_i_itag,
    input  logic [CH_NUM-1:0]        ch_wbck_i_err,
    input  logic [CH_NUM-1:0]        ch_cmt_i_ld,
    input  logic [CH_NUM-1:0]        ch_cmt_i_st,
    input  logic [CH_NUM-1:0]        ch_cmt_i_buserr,
    input  logic [CH_NUM*XLEN-1:0]   ch_cmt_i_badaddr,
    output logic                     longp_wbck_o_valid,
    input  logic                     longp_wbck_o_ready,
    output logic [XLEN-1:0]          longp_wbck_o_wdat,
    output logic [4:0]               longp_wbck_o_flags,
    output logic [4:0]               longp_wbck_o_rdidx,
    output logic                     longp_wbck_o_rdfpu,
    output logic                     longp_excp_o_valid,
    input  logic                     longp_excp_o_ready,
    output logic                     longp_excp_o_insterr,
    output logic                     longp_excp_o_ld,
    output logic                     longp_excp_o_st,
    output logic                     longp_excp_o_buserr,
    output logic [XLEN-1:0]          longp_excp_o_badaddr,
    output logic [XLEN-1:0]          longp_excp_o_pc,
    input  logic                     oitf_empty,
    input  logic [ITAG_W-1:0]        oitf_ret_ptr,
    input  logic [4:0]               oitf_ret_rdidx,
    input  logic [XLEN-1:0]          oitf_ret_pc,
    input  logic                     oitf_ret_rdwen,
    input  logic                     oitf_ret_rdfpu,
    output logic                     oitf_ret_ena,
    output logic                     buf_conflict_o
);
    typedef struct packed {
        logic [XLEN-1:0]   wdat;
        logic [ITAG_W-1:0] itag;
        logic              err;
        logic              ld;
        logic              st;
        logic              buserr;
        logic [XLEN-1:0]   badaddr;
    } ent_t;

    ent_t              in_ent [CH_NUM];
    ent_t              head   [CH_NUM];
    ent_t              sel_ent;
    logic [CH_NUM-1:0] empty, full, push, pop, match, sel_oh;
    logic              sel_vld, sel_byp, sel_mask;
    logic              need_wbck, need_excp, retire;

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        assign in_ent[c] = '{wdat:    ch_wbck_i_wdat[c*XLEN +: XLEN],
                             itag:    ch_wbck_i_itag[c*ITAG_W +: ITAG_W],
                             err:     ch_wbck_i_err[c],
                             ld:      ch_cmt_i_ld[c],
                             st:      ch_cmt_i_st[c],
                             buserr:  ch_cmt_i_buserr[c],
                             badaddr: ch_cmt_i_badaddr[c*XLEN +: XLEN]};

        assign match[c] = ~empty[c] & ~oitf_empty & (head[c].itag == oitf_ret_ptr);
        assign pop[c]   = retire & sel_oh[c] & ~sel_byp;
        // a bypassed result that retires never occupies the FIFO
        assign push[c]  = ch_wbck_i_valid[c] & ~full[c] & ~(retire & sel_byp & sel_oh[c]);
        assign ch_wbck_i_ready[c] = ~full[c];

        e203_longpwbck_fifo #(.DEP(BUF_DEP), .W($bits(ent_t))) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[c]),
            .pop   (pop[c]),
            .din   (in_ent[c]),
            .dout  (head[c]),
            .empty (empty[c]),
            .full  (full[c])
        );
    end

    // Lowest matching channel wins; buffered heads beat bypass candidates.
    always_comb begin
        sel_vld  = 1'b0;
        sel_byp  = 1'b0;
        sel_oh   = '0;
        sel_mask = 1'b0;
        sel_ent  = '0;
        for (int c = CH_NUM - 1; c >= 0; c--) begin
            if (match[c]) begin
                sel_vld  = 1'b1;
                sel_oh   = '0;
                sel_oh[c] = 1'b1;
                sel_mask = CH_EXCP_MASK[c];
                sel_ent  = head[c];
            end
        end
`ifdef E203_LONGPWBCK_BYPASS_EN
        if (!sel_vld) begin
            for (int c = CH_NUM - 1; c >= 0; c--) begin
                if (ch_wbck_i_valid[c] && empty[c] && !oitf_empty &&
                    (in_ent[c].itag == oitf_ret_ptr)) begin
                    sel_byp  = 1'b1;
                    sel_oh   = '0;
                    sel_oh[c] = 1'b1;
                    sel_mask = CH_EXCP_MASK[c];
                    sel_ent  = in_ent[c];
                end
            end
            sel_vld = sel_byp;
        end
`endif
    end

    assign buf_conflict_o = ($countones(match) > 1);

    // need_wbck uses the raw error so a suppressed fault retires silently
    assign need_wbck = oitf_ret_rdwen & ~sel_ent.err;
    assign need_excp = sel_ent.err & sel_mask;

    assign longp_wbck_o_valid = need_wbck & sel_vld & (~need_excp | longp_excp_o_ready);
    assign longp_excp_o_valid = need_excp & sel_vld & (~need_wbck | longp_wbck_o_ready);
    assign retire = sel_vld & (~need_wbck | longp_wbck_o_ready) & (~need_excp | longp_excp_o_ready);
    assign oitf_ret_ena = retire;

    assign longp_wbck_o_wdat    = sel_ent.wdat;
    assign longp_wbck_o_flags   = 5'd0;
    assign longp_wbck_o_rdidx   = oitf_ret_rdidx;
    assign longp_wbck_o_rdfpu   = oitf_ret_rdfpu;
    assign longp_excp_o_insterr = 1'b0;
    assign longp_excp_o_ld      = sel_ent.ld;
    assign longp_excp_o_st      = sel_ent.st;
    assign longp_excp_o_buserr  = sel_ent.buserr;
    assign longp_excp_o_badaddr = sel_ent.badaddr;
    assign longp_excp_o_pc      = oitf_ret_pc;
endmodule

// File: tb/tb_e203_exu_longpwbck_buf.sv
// Scoreboard bench for e203_exu_longpwbck_buf: expected retires queued at drive time, matched by itag on oitf_ret_ena.
module tb_e203_exu_longpwbck_buf;
    localparam int CH = 2;
    localparam int XL = 32;
    localparam int IW = 5;
    localparam logic [CH-1:0] MASK = 2'b01;
`ifdef E203_LONGPWBCK_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clk = 0, rst_n = 0;
    logic [CH-1:0] ch_wbck_i_valid, ch_wbck_i_ready, ch_wbck_i_err;
    logic [CH-1:0] ch_cmt_i_ld, ch_cmt_i_st, ch_cmt_i_buserr;
    logic [CH*XL-1:0] ch_wbck_i_wdat, ch_cmt_i_badaddr;
    logic [CH*IW-1:0] ch_wbck_i_itag;
    logic longp_wbck_o_valid, longp_wbck_o_ready, longp_wbck_o_rdfpu;
    logic [XL-1:0] longp_wbck_o_wdat, longp_excp_o_badaddr, longp_excp_o_pc, oitf_ret_pc;
    logic [4:0] longp_wbck_o_flags, longp_wbck_o_rdidx, oitf_ret_rdidx;
    logic longp_excp_o_valid, longp_excp_o_ready, longp_excp_o_insterr;
    logic longp_excp_o_ld, longp_excp_o_st, longp_excp_o_buserr;
    logic oitf_empty, oitf_ret_rdwen, oitf_ret_rdfpu, oitf_ret_ena, buf_conflict_o;
    logic [IW-1:0] oitf_ret_ptr;

    e203_exu_longpwbck_buf dut (
        .clk(clk), .rst_n(rst_n),
        .ch_wbck_i_valid(ch_wbck_i_valid), .ch_wbck_i_ready(ch_wbck_i_ready),
        .ch_wbck_i_wdat(ch_wbck_i_wdat), .ch_wbck_i_itag(ch_wbck_i_itag),
        .ch_wbck_i_err(ch_wbck_i_err), .ch_cmt_i_ld(ch_cmt_i_ld), .ch_cmt_i_st(ch_cmt_i_st),
        .ch_cmt_i_buserr(ch_cmt_i_buserr), .ch_cmt_i_badaddr(ch_cmt_i_badaddr),
        .longp_wbck_o_valid(longp_wbck_o_valid), .longp_wbck_o_ready(longp_wbck_o_ready),
        .longp_wbck_o_wdat(longp_wbck_o_wdat), .longp_wbck_o_flags(longp_wbck_o_flags),
        .longp_wbck_o_rdidx(longp_wbck_o_rdidx), .longp_wbck_o_rdfpu(longp_wbck_o_rdfpu),
        .longp_excp_o_valid(longp_excp_o_valid), .longp_excp_o_ready(longp_excp_o_ready),
        .longp_excp_o_insterr(longp_excp_o_insterr), .longp_excp_o_ld(longp_excp_o_ld),
        .longp_excp_o_st(longp_excp_o_st), .longp_excp_o_buserr(longp_excp_o_buserr),
        .longp_excp_o_badaddr(longp_excp_o_badaddr), .longp_excp_o_pc(longp_excp_o_pc),
        .oitf_empty(oitf_empty), .oitf_ret_ptr(oitf_ret_ptr), .oitf_ret_rdidx(oitf_ret_rdidx),
        .oitf_ret_pc(oitf_ret_pc), .oitf_ret_rdwen(oitf_ret_rdwen), .oitf_ret_rdfpu(oitf_ret_rdfpu),
        .oitf_ret_ena(oitf_ret_ena), .buf_conflict_o(buf_conflict_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] itag;
        logic          wv;
        logic [XL-1:0] wdat;
        logic          ev;
        logic          ld;
        logic          buserr;
        logic [XL-1:0] badaddr;
    } rec_t;

    rec_t sb[$];
    int   errs = 0, checks = 0, ret_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        int   idx;
        rec_t r;
        if (rst_n && oitf_ret_ena) begin
            idx = -1;
            for (int i = 0; i < sb.size(); i++)
                if (idx < 0 && sb[i].itag == oitf_ret_ptr) idx = i;
            if (idx < 0) chk("sb_hit", 0, 1);
            else begin
                r = sb[idx];
                sb.delete(idx);
                chk("ret_wv", longp_wbck_o_valid, r.wv);
                if (r.wv) chk("ret_wdat", longp_wbck_o_wdat, r.wdat);
                chk("ret_ev", longp_excp_o_valid, r.ev);
                if (r.ev) begin
                    chk("ret_badaddr", longp_excp_o_badaddr, r.badaddr);
                    chk("ret_buserr", longp_excp_o_buserr, r.buserr);
                    chk("ret_ld", longp_excp_o_ld, r.ld);
                end
            end
            ret_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int ch, input logic [IW-1:0] itag, input logic [XL-1:0] wdat,
                       input logic err = 0, input logic ld = 0, input logic st = 0,
                       input logic be = 0, input logic [XL-1:0] ba = 0);
        rec_t r;
        ch_wbck_i_valid[ch]           = 1'b1;
        ch_wbck_i_itag[ch*IW +: IW]   = itag;
        ch_wbck_i_wdat[ch*XL +: XL]   = wdat;
        ch_wbck_i_err[ch]             = err;
        ch_cmt_i_ld[ch]               = ld;
        ch_cmt_i_st[ch]               = st;
        ch_cmt_i_buserr[ch]           = be;
        ch_cmt_i_badaddr[ch*XL +: XL] = ba;
        r.itag = itag; r.wdat = wdat; r.ld = ld; r.buserr = be; r.badaddr = ba;
        r.wv = oitf_ret_rdwen & ~err;
        r.ev = err & MASK[ch];
        sb.push_back(r);
    endtask

    task automatic clr();
        ch_wbck_i_valid = '0; ch_wbck_i_err = '0; ch_cmt_i_ld = '0; ch_cmt_i_st = '0;
        ch_cmt_i_buserr = '0; ch_wbck_i_itag = '0; ch_wbck_i_wdat = '0; ch_cmt_i_badaddr = '0;
    endtask

    task automatic wait_ret(input int start);
        for (int i = 0; i < 20; i++) begin
            if (ret_cnt > start) return;
            cyc();
        end
        chk("ret_timeout", 0, 1);
    endtask

    initial begin
        int s;
        clr();
        longp_wbck_o_ready = 1; longp_excp_o_ready = 1;
        oitf_empty = 1; oitf_ret_ptr = '0; oitf_ret_rdidx = 5'd7; oitf_ret_pc = 32'h100;
        oitf_ret_rdwen = 1; oitf_ret_rdfpu = 0;
        @(negedge clk);
        chk("rst_ready", ch_wbck_i_ready, 2'b11);
        chk("rst_wv", longp_wbck_o_valid, 0);
        chk("rst_ev", longp_excp_o_valid, 0);
        chk("rst_ena", oitf_ret_ena, 0);
        chk("rst_conf", buf_conflict_o, 0);
        cyc(); rst_n = 1; cyc();

        // in-order flow
        oitf_empty = 0; oitf_ret_ptr = 3; s = ret_cnt;
        put(0, 3, 32'h1234);
        @(negedge clk);
        chk("lat_ena", oitf_ret_ena, BYP);
        cyc(); clr();
        wait_ret(s);
        chk("inord_rdy", ch_wbck_i_ready, 2'b11);
        chk("rdidx", longp_wbck_o_rdidx, 5'd7);
        @(negedge clk);
        chk("inord_idle", oitf_ret_ena, 0);
        cyc();

        // out-of-order: ch1 fills while head waits for ch0
        oitf_ret_ptr = 4; s = ret_cnt;
        put(1, 5, 32'hA5); cyc(); clr();
        @(negedge clk);
        chk("ooo_hold", oitf_ret_ena, 0);
        chk("ooo_rdy1", ch_wbck_i_ready[1], 1);
        cyc();
        put(1, 6, 32'hA6); cyc(); clr();
        chk("ooo_full", ch_wbck_i_ready, 2'b01);
        put(0, 4, 32'h44); cyc(); clr();
        wait_ret(s);
        oitf_ret_ptr = 5; s = ret_cnt; wait_ret(s);
        chk("ooo_rdy_back", ch_wbck_i_ready[1], 1);
        oitf_ret_ptr = 6; s = ret_cnt; wait_ret(s);
        chk("ooo_rdy_all", ch_wbck_i_ready, 2'b11);

        // exception stalled on excp_ready
        oitf_ret_ptr = 7; oitf_ret_pc = 32'h200; longp_excp_o_ready = 0; s = ret_cnt;
        put(0, 7, 32'h77, 1, 1, 0, 1, 32'h8000_0010); cyc(); clr();
        repeat (3) begin
            @(negedge clk);
            chk("exc_ev", longp_excp_o_valid, 1);
            chk("exc_ena", oitf_ret_ena, 0);
            chk("exc_wv", longp_wbck_o_valid, 0);
            chk("exc_badaddr", longp_excp_o_badaddr, 32'h8000_0010);
            chk("exc_pc", longp_excp_o_pc, 32'h200);
        end
        cyc(); longp_excp_o_ready = 1;
        wait_ret(s);

        // masked error on ch1 retires silently
        oitf_ret_ptr = 8; s = ret_cnt;
        put(1, 8, 32'h88, 1); cyc(); clr();
        wait_ret(s);

        // oitf_empty blocks, then two heads conflict and ch0 wins
        oitf_empty = 1; oitf_ret_ptr = 12;
        put(0, 12, 32'hC0); put(1, 12, 32'hC1); cyc(); clr();
        @(negedge clk);
        chk("empty_ena", oitf_ret_ena, 0);
        chk("empty_conf", buf_conflict_o, 0);
        cyc(); oitf_empty = 0;
        @(negedge clk);
        chk("conf_flag", buf_conflict_o, 1);
        chk("conf_wdat", longp_wbck_o_wdat, 32'hC0);
        cyc(); s = ret_cnt; wait_ret(s);
        @(negedge clk);
        chk("conf_clear", buf_conflict_o, 0);
        cyc();

        // write-back stall, then reset mid-stall
        oitf_ret_ptr = 9; longp_wbck_o_ready = 0;
        put(0, 9, 32'h99); cyc(); clr();
        repeat (5) begin
            @(negedge clk);
            chk("stall_wv", longp_wbck_o_valid, 1);
            chk("stall_wdat", longp_wbck_o_wdat, 32'h99);
            chk("stall_ena", oitf_ret_ena, 0);
        end
        cyc();
        put(0, 10, 32'h10A); cyc(); clr();
        chk("stall_full", ch_wbck_i_ready, 2'b10);
        rst_n = 0; #1;
        chk("mrst_ready", ch_wbck_i_ready, 2'b11);
        chk("mrst_wv", longp_wbck_o_valid, 0);
        chk("mrst_ev", longp_excp_o_valid, 0);
        chk("mrst_ena", oitf_ret_ena, 0);
        sb.delete();
        cyc(); rst_n = 1; longp_wbck_o_ready = 1;
        @(negedge clk);
        chk("post_rst_ena", oitf_ret_ena, 0);
        chk("sb_empty", sb.size(), 0);
        cyc();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/e203_exu_longpwbck_buf.md
Name: e203_exu_longpwbck_buf

Overview:
Parametrised long-pipe write-back arbiter for CH_NUM long-pipe units (LSU, NICE, future FPU/DIV).
- Each channel gets a small result FIFO, so a unit completes and frees itself even when its itag is not yet at the OITF head.
- Each cycle, the buffered head whose itag equals oitf_ret_ptr is retired to the final write-back stage and/or the commit exception interface.
- Sits between the long-pipe units and e203_exu_wbck/commit.

Parameters:
CH_NUM, 2, number of long-pipe channels (1..4)
XLEN, 32, data and address width
ITAG_W, 5, OITF itag width
BUF_DEP, 2, per-channel result FIFO depth (>=1; need not be a power of 2)
CH_EXCP_MASK, 2'b01, per-channel bit: 1 = errors go to commit exception; 0 = error suppressed (NICE style)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ch_wbck_i_valid  in  CH_NUM  per-channel result valid
ch_wbck_i_ready  out  CH_NUM  per-channel FIFO not full
ch_wbck_i_wdat  in  CH_NUM*XLEN  result data, channel c at [c*XLEN +: XLEN]
ch_wbck_i_itag  in  CH_NUM*ITAG_W  result itag
ch_wbck_i_err  in  CH_NUM  result error
ch_cmt_i_ld  in  CH_NUM  faulting access was a load
ch_cmt_i_st  in  CH_NUM  faulting access was a store
ch_cmt_i_buserr  in  CH_NUM  bus error
ch_cmt_i_badaddr  in  CH_NUM*XLEN  faulting address
longp_wbck_o_valid  out  1  write-back valid
longp_wbck_o_ready  in  1  write-back ready
longp_wbck_o_wdat  out  XLEN  write-back data
longp_wbck_o_flags  out  5  always 0
longp_wbck_o_rdidx  out  5  equals oitf_ret_rdidx
longp_wbck_o_rdfpu  out  1  equals oitf_ret_rdfpu
longp_excp_o_valid  out  1  exception valid
longp_excp_o_ready  in  1  exception ready
longp_excp_o_insterr  out  1  always 0
longp_excp_o_ld  out  1  from selected channel entry; 0 when none selected
longp_excp_o_st  out  1  from selected channel entry; 0 when none selected
longp_excp_o_buserr  out  1  from selected channel entry; 0 when none selected
longp_excp_o_badaddr  out  XLEN  from selected channel entry; 0 when none selected
longp_excp_o_pc  out  XLEN  equals oitf_ret_pc
oitf_empty  in  1  OITF empty
oitf_ret_ptr  in  ITAG_W  itag of the OITF head
oitf_ret_rdidx  in  5  rd index of the OITF head
oitf_ret_pc  in  XLEN  PC of the OITF head
oitf_ret_rdwen  in  1  OITF head writes rd
oitf_ret_rdfpu  in  1  OITF head rd is an FPU register
oitf_ret_ena  out  1  OITF head retired this cycle
buf_conflict_o  out  1  more than one buffered head matches the OITF head (error flag)

Behaviour:
Reset:
- All FIFOs empty, pointers 0.
- ch_wbck_i_ready all 1; all valid outputs, oitf_ret_ena and buf_conflict_o are 0.

Per-channel FIFO:
- Entry = {wdat, itag, err, ld, st, buserr, badaddr}.
- ch_wbck_i_ready[c] = ~full[c]. It is registered-state only: no combinational path from longp_*_ready.
- Push on valid & ready. Pop on retire of that channel.
- Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo BUF_DEP.

Selection:
- match[c] = ~empty[c] & ~oitf_empty & (head_itag[c] == oitf_ret_ptr).
- The lowest matching index wins.
- buf_conflict_o = more than one match[c] set (combinational). It is never expected in normal operation.

Retire logic (on the selected head):
- err_eff = err & CH_EXCP_MASK[c].
- need_wbck = oitf_ret_rdwen & ~err.
- need_excp = err_eff.
- wbck_i_valid = any match.
- longp_wbck_o_valid = need_wbck & wbck_i_valid & (need_excp ? longp_excp_o_ready : 1).
- longp_excp_o_valid = need_excp & wbck_i_valid & (need_wbck ? longp_wbck_o_ready : 1).
- retire = wbck_i_valid & (need_wbck ? longp_wbck_o_ready : 1) & (need_excp ? longp_excp_o_ready : 1).
- oitf_ret_ena = retire; the selected FIFO pops on retire.
- An error suppressed by CH_EXCP_MASK with rdwen set: the entry retires silently with no write-back.
- At most one retire per cycle.

Latency: minimum 1 cycle from input acceptance to output valid (without bypass).

oitf_empty: no selection; all FIFOs hold.

Output stability: outputs are held while stalled, because the FIFO head does not change until retire.

Optional Feature:
Macro E203_LONGPWBCK_BYPASS_EN.
- Defined: if FIFO[c] is empty and the incoming itag equals oitf_ret_ptr (oitf not empty), the incoming result is a retire candidate in the same cycle (0 latency).
  - Buffered matches take priority over bypass candidates.
  - If it retires, it is not written to the FIFO; otherwise it is pushed normally.
- Undefined: all results pass through the FIFO; minimum latency 1 cycle.

Test Plan:
- In-order flow: ch0 pushes itag 3, wdat 0x1234, OITF head ptr 3, rdwen 1, wbck_ready 1 -> next cycle longp_wbck_o_valid=1, wdat 0x1234, oitf_ret_ena=1; FIFO empties.
- Out-of-order results: ch1 pushes itag 5 while head ptr is 4 -> held, ready stays 1 until BUF_DEP entries fill, then ch_wbck_i_ready[1]=0; ch0 itag 4 retires, ptr moves to 5, then ch1 retires next cycle.
- Exception path: ch0 err=1, buserr=1, badaddr 0x8000_0010, excp_ready 0 -> excp_valid=1, no retire and outputs stable; excp_ready 1 -> oitf_ret_ena=1, wbck_valid never asserted.
- Masked error: ch1 (mask 0) err=1, rdwen=1 -> both valids 0, oitf_ret_ena=1 in the match cycle.
- Stall and reset: wbck_ready held 0 for 5 cycles -> FIFO count constant, no pop; assert rst_n low mid-stall -> all FIFOs empty, outputs 0 immediately.
- Bypass (macro defined): empty FIFO, incoming itag equals ptr -> oitf_ret_ena in the same cycle and no FIFO write; without the macro, 1-cycle delay.
